// File: rtl/serial_command_decoder_if.sv
// ---------------------------------------------------------------------------
// serial_command_decoder_if
//   Bundles the byte-stream input, the payload write port toward the core and
//   the frame status outputs of serial_command_decoder.
//
//   Signals
//     rx_data    [7:0]   received byte, valid while rx_finish=1
//     rx_finish          one-cycle strobe: rx_data holds a new byte
//     busy               frame in progress (SYNC accepted .. commit/abort)
//     cmd        [7:0]   CMD of the last committed frame
//     wr_en              payload write request
//     wr_addr    [AW-1:0] payload byte index
//     wr_data    [7:0]   payload byte
//     wr_ready           core accepts a write when wr_en & wr_ready
//     done               one-cycle pulse: frame committed
//     error              one-cycle pulse: frame aborted or byte dropped
//     error_code [1:0]   00 timeout, 01 checksum, 10 length, 11 overrun
//
//   Modports
//     slave  : the decoder (consumes bytes, drives the write port and status)
//     master : the environment (byte source, core write port, status sink)
// ---------------------------------------------------------------------------
interface serial_command_decoder_if #(
  parameter int AddressWidth = 4
) ();
  logic [7:0]              rx_data;
  logic                    rx_finish;
  logic                    busy;
  logic [7:0]              cmd;
  logic                    wr_en;
  logic [AddressWidth-1:0] wr_addr;
  logic [7:0]              wr_data;
  logic                    wr_ready;
  logic                    done;
  logic                    error;
  logic [1:0]              error_code;

  modport slave (
    input  rx_data,
    input  rx_finish,
    input  wr_ready,
    output busy,
    output cmd,
    output wr_en,
    output wr_addr,
    output wr_data,
    output done,
    output error,
    output error_code
  );

  modport master (
    output rx_data,
    output rx_finish,
    output wr_ready,
    input  busy,
    input  cmd,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  done,
    input  error,
    input  error_code
  );
endinterface

// File: rtl/serial_command_decoder.sv
// ---------------------------------------------------------------------------
// serial_command_decoder
//   Parses framed command packets from a byte stream:
//     SYNC, CMD, LEN, LEN payload bytes, CHK
//   where CHK = (CMD + LEN + sum(payload)) mod 256. The payload is buffered
//   in a small RAM and is only written to the core's load port once the
//   checksum has matched. Malformed, oversized or stalled frames are aborted
//   with an error pulse; a byte arriving while a commit is running is
//   dropped and reported as an overrun.
//
//   Parameters
//     AddressWidth  payload buffer depth = 2**AddressWidth bytes (1..7)
//     SyncByte      frame start marker
//     TimeoutWidth  width of the inter-byte gap counter
//     TimeoutCycles max cycles between bytes inside a frame (>0, fits width)
//
//   Ports
//     clk   system clock, all logic on the rising edge
//     rst   synchronous active-high reset; discards any frame silently
//     bus   serial_command_decoder_if.slave (byte input, write port, status)
// ---------------------------------------------------------------------------
module serial_command_decoder #(
  parameter int         AddressWidth  = 4,
  parameter logic [7:0] SyncByte      = 8'hA5,
  parameter int         TimeoutWidth  = 16,
  parameter int         TimeoutCycles = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_command_decoder_if.slave  bus
);

  localparam int Depth    = 2 ** AddressWidth;
  // One extra bit so that a length of exactly Depth is representable.
  localparam int IdxWidth = AddressWidth + 1;

  localparam logic [8:0]              MaxLen    = 9'(Depth);
  localparam logic [TimeoutWidth-1:0] TimerLast = TimeoutWidth'(TimeoutCycles - 1);

  localparam logic [1:0] ErrTimeout  = 2'b00;
  localparam logic [1:0] ErrChecksum = 2'b01;
  localparam logic [1:0] ErrLength   = 2'b10;
  localparam logic [1:0] ErrOverrun  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_COMMIT
  } state_t;

  state_t                  state_reg,        state_next;
  logic [7:0]              cmd_tmp_reg,      cmd_tmp_next;
  logic [IdxWidth-1:0]     len_reg,          len_next;
  logic [7:0]              sum_reg,          sum_next;
  logic [IdxWidth-1:0]     idx_reg,          idx_next;
  logic [7:0]              cmd_reg,          cmd_next;
  logic                    done_reg,         done_next;
  logic                    error_reg,        error_next;
  logic [1:0]              error_code_reg,   error_code_next;
  logic                    overrun_pend_reg, overrun_pend_next;
  logic [TimeoutWidth-1:0] timer_reg,        timer_next;

  logic                    payload_we;
  logic                    write_req;
  logic                    commit_finish;
  logic                    frame_active;

  // Payload buffer: written during PAYLOAD, read with one cycle of latency.
  logic [7:0]              payload_mem [0:Depth-1];
  logic [7:0]              rd_data_reg;

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      cmd_tmp_reg      <= 8'h00;
      len_reg          <= '0;
      sum_reg          <= 8'h00;
      idx_reg          <= '0;
      cmd_reg          <= 8'h00;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
      error_code_reg   <= 2'b00;
      overrun_pend_reg <= 1'b0;
      timer_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      cmd_tmp_reg      <= cmd_tmp_next;
      len_reg          <= len_next;
      sum_reg          <= sum_next;
      idx_reg          <= idx_next;
      cmd_reg          <= cmd_next;
      done_reg         <= done_next;
      error_reg        <= error_next;
      error_code_reg   <= error_code_next;
      overrun_pend_reg <= overrun_pend_next;
      timer_reg        <= timer_next;
    end
  end

  // ------------------------------------------------------------------------
  // Payload RAM. The read address is the *next* index, so rd_data_reg always
  // holds payload_mem[idx_reg]: wr_data is valid on the first COMMIT cycle,
  // follows each accepted transfer without a bubble and stays put on stalls.
  // No write can hit the RAM in COMMIT, so there is no read/write hazard.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (payload_we) begin
      payload_mem[idx_reg[AddressWidth-1:0]] <= bus.rx_data;
    end
    rd_data_reg <= payload_mem[idx_next[AddressWidth-1:0]];
  end

  // ------------------------------------------------------------------------
  // Next-state and output logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    cmd_tmp_next      = cmd_tmp_reg;
    len_next          = len_reg;
    sum_next          = sum_reg;
    idx_next          = idx_reg;
    cmd_next          = cmd_reg;
    done_next         = 1'b0;
    error_next        = 1'b0;
    error_code_next   = error_code_reg;
    overrun_pend_next = 1'b0;
    timer_next        = timer_reg;
    payload_we        = 1'b0;
    write_req         = 1'b0;
    commit_finish     = 1'b0;
    frame_active      = 1'b0;

    // An overrun that coincided with the done pulse is reported one cycle
    // later. The FSM is in IDLE then, which raises no error of its own.
    if (overrun_pend_reg) begin
      error_next      = 1'b1;
      error_code_next = ErrOverrun;
    end

    case (state_reg)
      S_IDLE: begin
        if (bus.rx_finish && (bus.rx_data == SyncByte)) begin
          state_next = S_CMD;
        end
      end

      S_CMD: begin
        if (bus.rx_finish) begin
          cmd_tmp_next = bus.rx_data;
          sum_next     = bus.rx_data;
          state_next   = S_LEN;
        end
      end

      S_LEN: begin
        if (bus.rx_finish) begin
          sum_next = sum_reg + bus.rx_data;
          len_next = bus.rx_data[IdxWidth-1:0];
          if ({1'b0, bus.rx_data} > MaxLen) begin
            error_next      = 1'b1;
            error_code_next = ErrLength;
            state_next      = S_IDLE;
          end else if (bus.rx_data == 8'h00) begin
            state_next = S_CHK;
          end else begin
            idx_next   = '0;
            state_next = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        // SYNC-valued bytes are ordinary data here.
        if (bus.rx_finish) begin
          payload_we = 1'b1;
          sum_next   = sum_reg + bus.rx_data;
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == (len_reg - 1'b1)) begin
            state_next = S_CHK;
          end
        end
      end

      S_CHK: begin
        if (bus.rx_finish) begin
          if (bus.rx_data == sum_reg) begin
            idx_next   = '0;
            state_next = S_COMMIT;
          end else begin
            error_next      = 1'b1;
            error_code_next = ErrChecksum;
            state_next      = S_IDLE;
          end
        end
      end

      S_COMMIT: begin
        write_req = (len_reg != '0);
        if (len_reg == '0) begin
          commit_finish = 1'b1;
        end else if (bus.wr_ready) begin
          idx_next = idx_reg + 1'b1;
          if (idx_reg == (len_reg - 1'b1)) begin
            commit_finish = 1'b1;
          end
        end

        if (commit_finish) begin
          cmd_next   = cmd_tmp_reg;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end

        // Bytes cannot be buffered while committing: drop and report, but
        // never on the same cycle as done.
        if (bus.rx_finish) begin
          if (commit_finish) begin
            overrun_pend_next = 1'b1;
          end else begin
            error_next      = 1'b1;
            error_code_next = ErrOverrun;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Inter-byte gap supervision. A byte arriving on the limit cycle wins.
    frame_active = (state_reg == S_CMD) || (state_reg == S_LEN) ||
                   (state_reg == S_PAYLOAD) || (state_reg == S_CHK);
    if (!frame_active || bus.rx_finish) begin
      timer_next = '0;
    end else if (timer_reg == TimerLast) begin
      timer_next      = '0;
      error_next      = 1'b1;
      error_code_next = ErrTimeout;
      state_next      = S_IDLE;
    end else begin
      timer_next = timer_reg + 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign bus.busy       = (state_reg != S_IDLE);
  assign bus.cmd        = cmd_reg;
  assign bus.wr_en      = write_req;
  assign bus.wr_addr    = idx_reg[AddressWidth-1:0];
  assign bus.wr_data    = rd_data_reg;
  assign bus.done       = done_reg;
  assign bus.error      = error_reg;
  assign bus.error_code = error_code_reg;

endmodule
